// File: rtl/blackjack_round_ctrl.sv
// blackjack_round_ctrl
//
// Sequences one blackjack round. It deals player, dealer, player, dealer
// from the shared card source, runs the player's hit/stand turn and the
// dealer's automatic draw rule, and then latches the verdict.
//
// Ports:
//   clk, reset            system clock, synchronous active-high reset
//   start, hit, stand     single-cycle control pulses from the button logic
//   card_valid/value      card source handshake (rank 1..13)
//   card_req, card_dest   card request (registered) and destination (0 player, 1 dealer)
//   player_sum/dealer_sum best hand totals (ace counted 11 when it fits)
//   phase                 state code (debug)
//   done                  high while the verdict is shown
//   win/lose/draw/blackjack verdict flags, valid while done
//
// Build option: define DEALER_HITS_SOFT17_EN to make the dealer draw on a
// soft 17 (ace held and hard total 7).
//
// state    | meaning
// IDLE     | waiting for start
// DEAL_P1  | first card to player
// DEAL_D1  | first card to dealer
// DEAL_P2  | second card to player
// DEAL_D2  | second card to dealer, blackjack check on accept
// PLAYER   | waiting for hit or stand (auto-stand on 21)
// P_DRAW   | player hit card, bust check on accept
// DEALER   | dealer draws while below 17
// RESULT   | verdict held until start
module blackjack_round_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       hit,
  input  logic       stand,
  input  logic       card_valid,
  input  logic [4:0] card_value,
  output logic       card_req,
  output logic       card_dest,
  output logic [5:0] player_sum,
  output logic [5:0] dealer_sum,
  output logic [2:0] phase,
  output logic       done,
  output logic       win,
  output logic       lose,
  output logic       draw,
  output logic       blackjack
);

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_DEAL_P1 = 4'd1,
    S_DEAL_D1 = 4'd2,
    S_DEAL_P2 = 4'd3,
    S_DEAL_D2 = 4'd4,
    S_PLAYER  = 4'd5,
    S_P_DRAW  = 4'd6,
    S_DEALER  = 4'd7,
    S_RESULT  = 4'd8
  } state_t;

  state_t     state, state_n;
  logic [5:0] p_hard, d_hard, p_hard_n, d_hard_n;
  logic       p_ace, d_ace, p_ace_n, d_ace_n;
  logic [5:0] p_best_n, d_best_n;
  logic [5:0] card_pts;
  logic       rank_ok, accept, dealer_draw, req_state;
  logic       clear, load_verdict;
  logic       v_win, v_lose, v_draw;

  // hard + 10 <= 21 is the same as hard <= 11
  function automatic logic [5:0] best_of(input logic [5:0] hard, input logic ace);
    return (ace && hard <= 6'd11) ? hard + 6'd10 : hard;
  endfunction

  assign rank_ok  = (card_value >= 5'd1) && (card_value <= 5'd13);
  assign card_pts = (card_value > 5'd10) ? 6'd10 : {1'b0, card_value};
  assign accept   = card_req && card_valid && rank_ok;

  assign card_dest = (state == S_DEAL_D1) || (state == S_DEAL_D2) || (state == S_DEALER);

  assign player_sum = best_of(p_hard, p_ace);
  assign dealer_sum = best_of(d_hard, d_ace);
  assign done       = (state == S_RESULT);
  // Nine states share a 3-bit debug code: RESULT reports 7 like DEALER,
  // and done tells the two apart.
  assign phase      = (state == S_RESULT) ? 3'd7 : 3'(state);

`ifdef DEALER_HITS_SOFT17_EN
  assign dealer_draw = (dealer_sum < 6'd17) || (d_ace && d_hard == 6'd7);
`else
  assign dealer_draw = (dealer_sum < 6'd17);
`endif

  assign req_state = (state == S_DEAL_P1) || (state == S_DEAL_D1) ||
                     (state == S_DEAL_P2) || (state == S_DEAL_D2) ||
                     (state == S_P_DRAW)  || ((state == S_DEALER) && dealer_draw);

  // Hand values as they will be after this edge; verdicts are judged on these.
  always_comb begin
    p_hard_n = p_hard;
    p_ace_n  = p_ace;
    d_hard_n = d_hard;
    d_ace_n  = d_ace;
    if (accept) begin
      if (card_dest) begin
        d_hard_n = d_hard + card_pts;
        d_ace_n  = d_ace | (card_value == 5'd1);
      end else begin
        p_hard_n = p_hard + card_pts;
        p_ace_n  = p_ace | (card_value == 5'd1);
      end
    end
  end

  assign p_best_n = best_of(p_hard_n, p_ace_n);
  assign d_best_n = best_of(d_hard_n, d_ace_n);

  always_comb begin
    state_n      = state;
    clear        = 1'b0;
    load_verdict = 1'b0;
    v_win        = 1'b0;
    v_lose       = 1'b0;
    v_draw       = 1'b0;

    if (p_best_n > 6'd21)                               v_lose = 1'b1;
    else if (d_best_n > 6'd21 || p_best_n > d_best_n)   v_win  = 1'b1;
    else if (p_best_n == d_best_n)                      v_draw = 1'b1;
    else                                                v_lose = 1'b1;

    case (state)
      S_IDLE, S_RESULT: begin
        if (start) begin
          clear   = 1'b1;
          state_n = S_DEAL_P1;
        end
      end
      S_DEAL_P1: if (accept) state_n = S_DEAL_D1;
      S_DEAL_D1: if (accept) state_n = S_DEAL_P2;
      S_DEAL_P2: if (accept) state_n = S_DEAL_D2;
      S_DEAL_D2: begin
        if (accept) begin
          if (p_best_n == 6'd21) begin
            state_n      = S_RESULT;
            load_verdict = 1'b1;
          end else begin
            state_n = S_PLAYER;
          end
        end
      end
      S_PLAYER: begin
        if (player_sum == 6'd21 || stand) state_n = S_DEALER;
        else if (hit)                     state_n = S_P_DRAW;
      end
      S_P_DRAW: begin
        if (accept) begin
          if (p_best_n > 6'd21) begin
            state_n      = S_RESULT;
            load_verdict = 1'b1;
          end else begin
            state_n = S_PLAYER;
          end
        end
      end
      S_DEALER: begin
        if (!dealer_draw) begin
          state_n      = S_RESULT;
          load_verdict = 1'b1;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      card_req  <= 1'b0;
      p_hard    <= 6'd0;
      p_ace     <= 1'b0;
      d_hard    <= 6'd0;
      d_ace     <= 1'b0;
      win       <= 1'b0;
      lose      <= 1'b0;
      draw      <= 1'b0;
      blackjack <= 1'b0;
    end else begin
      state    <= state_n;
      card_req <= req_state && !accept;
      if (clear) begin
        p_hard    <= 6'd0;
        p_ace     <= 1'b0;
        d_hard    <= 6'd0;
        d_ace     <= 1'b0;
        win       <= 1'b0;
        lose      <= 1'b0;
        draw      <= 1'b0;
        blackjack <= 1'b0;
      end else begin
        p_hard <= p_hard_n;
        p_ace  <= p_ace_n;
        d_hard <= d_hard_n;
        d_ace  <= d_ace_n;
        if (load_verdict) begin
          win       <= v_win;
          lose      <= v_lose;
          draw      <= v_draw;
          blackjack <= (state == S_DEAL_D2);
        end
      end
    end
  end

endmodule

// File: tb/tb_blackjack_round_ctrl.sv
`timescale 1ns/1ps
module tb_blackjack_round_ctrl;

  logic       clk = 1'b0;
  logic       reset, start, hit, stand, card_valid;
  logic [4:0] card_value;
  logic       card_req, card_dest, done, win, lose, draw, blackjack;
  logic [5:0] player_sum, dealer_sum;
  logic [2:0] phase;

  blackjack_round_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .hit(hit), .stand(stand),
    .card_valid(card_valid), .card_value(card_value),
    .card_req(card_req), .card_dest(card_dest),
    .player_sum(player_sum), .dealer_sum(dealer_sum), .phase(phase),
    .done(done), .win(win), .lose(lose), .draw(draw), .blackjack(blackjack)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef int card_arr_t [24];

  typedef struct {
    logic [7:0][4:0] c;
    int thr;
    int ps, ds;
    bit w, l, dr, bj;
  } vec_t;

  vec_t vecs [11];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference model: hands are plain lists of ranks.
  function automatic int hand_hard(input int h[$]);
    int s = 0;
    foreach (h[i]) s += (h[i] > 10) ? 10 : h[i];
    return s;
  endfunction

  function automatic bit has_ace(input int h[$]);
    foreach (h[i]) if (h[i] == 1) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int hand_best(input int h[$]);
    int s = hand_hard(h);
    if (has_ace(h) && s + 10 <= 21) s += 10;
    return s;
  endfunction

  function automatic bit dealer_hits(input int h[$]);
`ifdef DEALER_HITS_SOFT17_EN
    return (hand_best(h) < 17) || (has_ace(h) && hand_hard(h) == 7);
`else
    return hand_best(h) < 17;
`endif
  endfunction

  // Player hits while best < thr and not 21, then the dealer plays.
  function automatic void model_round(input card_arr_t c, input int thr,
      output int ps, output int ds, output bit w, output bit l, output bit dr,
      output bit bj, output int ncards, output int nhits, output logic [23:0] dest);
    int ph[$];
    int dh[$];
    int k;
    ph = {c[0], c[2]};
    dh = {c[1], c[3]};
    dest = '0;
    dest[1] = 1'b1;
    dest[3] = 1'b1;
    k = 4; nhits = 0; w = 0; l = 0; dr = 0; bj = 0;
    if (hand_best(ph) == 21) begin
      bj = 1;
    end else begin
      while (hand_best(ph) < thr && hand_best(ph) < 21 && k < 24) begin
        ph.push_back(c[k]); k++; nhits++;
      end
      if (hand_best(ph) <= 21)
        while (dealer_hits(dh) && k < 24) begin
          dh.push_back(c[k]); dest[k] = 1'b1; k++;
        end
    end
    ps = hand_best(ph);
    ds = hand_best(dh);
    if (ps > 21)                 l = 1;
    else if (ds > 21 || ps > ds) w = 1;
    else if (ps == ds)           dr = 1;
    else                         l = 1;
    ncards = k;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1; start = 0; hit = 0; stand = 0; card_valid = 0; card_value = 0;
    @(negedge clk);
    reset = 0;
  endtask

  task automatic run_round(input string tag, input card_arr_t c, input int thr,
      input int eps, input int eds, input bit ew, input bit el, input bit edr, input bit ebj);
    int mps, mds, ncards, nhits, k, hits_done, r;
    bit mw, ml, mdr, mbj, fin;
    logic [23:0] dest;
    model_round(c, thr, mps, mds, mw, ml, mdr, mbj, ncards, nhits, dest);
    k = 0; hits_done = 0; fin = 0;
    @(negedge clk);
    start = 1;
    for (int cyc = 0; cyc < 800; cyc++) begin
      @(negedge clk);
      start = 0; hit = 0; stand = 0; card_valid = 0;
      card_value = 5'($urandom_range(0, 31));
      if (done) begin
        fin = 1;
        break;
      end
      if (phase == 3'd0 || phase == 3'd5) chk({tag, " req_quiet"}, card_req, 0);
      if (card_req) begin
        r = $urandom_range(0, 7);
        if (r == 1) begin
          card_valid = 1;
          card_value = $urandom_range(0, 1) ? 5'd0 : 5'($urandom_range(14, 31));
        end else if (r != 0) begin
          if (k >= ncards) begin
            chk({tag, " extra_card_req"}, k, ncards - 1);
            break;
          end
          chk({tag, " card_dest"}, card_dest, dest[k]);
          card_valid = 1;
          card_value = 5'(c[k]);
          k++;
        end
      end else if (phase == 3'd5) begin
        if (hits_done < nhits) begin
          hit = 1;
          hits_done++;
        end else begin
          stand = 1;
          hit = 1'($urandom_range(0, 1));
        end
      end
    end
    chk({tag, " reached_result"}, fin, 1);
    chk({tag, " cards_used"}, k, ncards);
    chk({tag, " player_sum"}, player_sum, eps);
    chk({tag, " dealer_sum"}, dealer_sum, eds);
    chk({tag, " win"}, win, ew);
    chk({tag, " lose"}, lose, el);
    chk({tag, " draw"}, draw, edr);
    chk({tag, " blackjack"}, blackjack, ebj);
  endtask

  task automatic give_card(input string tag, input int v);
    int n = 0;
    while (!card_req && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk({tag, " card_req_seen"}, card_req, 1);
    card_valid = 1;
    card_value = 5'(v);
    @(negedge clk);
    card_valid = 0;
  endtask

  function automatic vec_t mkv(input int a0, a1, a2, a3, a4, a5, a6, a7,
      input int thr, ps, ds, input bit w, l, dr, bj);
    vec_t v;
    v.c[0] = 5'(a0); v.c[1] = 5'(a1); v.c[2] = 5'(a2); v.c[3] = 5'(a3);
    v.c[4] = 5'(a4); v.c[5] = 5'(a5); v.c[6] = 5'(a6); v.c[7] = 5'(a7);
    v.thr = thr; v.ps = ps; v.ds = ds;
    v.w = w; v.l = l; v.dr = dr; v.bj = bj;
    return v;
  endfunction

  initial begin
    card_arr_t cards;
    int mps, mds, ncards, nhits, n;
    bit mw, ml, mdr, mbj, any_req;
    logic [23:0] dest;

    //                 cards                      thr ps  ds  w  l  dr bj
    vecs[0]  = mkv(8, 5, 7, 9, 4, 0, 0, 0,   12, 15, 18, 0, 1, 0, 0);
    vecs[1]  = mkv(1, 6, 13, 10, 0, 0, 0, 0, 12, 21, 16, 1, 0, 0, 1);
    vecs[2]  = mkv(10, 10, 6, 5, 9, 0, 0, 0, 17, 25, 15, 0, 1, 0, 0);
    vecs[3]  = mkv(10, 10, 6, 5, 3, 0, 0, 0, 12, 16, 18, 0, 1, 0, 0);
`ifdef DEALER_HITS_SOFT17_EN
    vecs[4]  = mkv(10, 1, 9, 6, 5, 10, 0, 0, 12, 19, 22, 1, 0, 0, 0);
`else
    vecs[4]  = mkv(10, 1, 9, 6, 5, 10, 0, 0, 12, 19, 17, 1, 0, 0, 0);
`endif
    vecs[5]  = mkv(5, 10, 6, 7, 10, 0, 0, 0, 21, 21, 17, 1, 0, 0, 0);
    vecs[6]  = mkv(10, 10, 8, 8, 0, 0, 0, 0, 12, 18, 18, 0, 0, 1, 0);
    vecs[7]  = mkv(10, 6, 8, 10, 10, 0, 0, 0, 12, 18, 26, 1, 0, 0, 0);
    vecs[8]  = mkv(1, 1, 10, 13, 0, 0, 0, 0, 12, 21, 21, 0, 0, 1, 1);
    vecs[9]  = mkv(1, 5, 5, 10, 10, 3, 2, 0, 18, 19, 17, 1, 0, 0, 0);
    vecs[10] = mkv(10, 10, 7, 9, 0, 0, 0, 0, 12, 17, 19, 0, 1, 0, 0);

    reset = 1; start = 0; hit = 0; stand = 0; card_valid = 0; card_value = 0;
    @(negedge clk);
    @(negedge clk);
    chk("rst card_req", card_req, 0);
    chk("rst card_dest", card_dest, 0);
    chk("rst player_sum", player_sum, 0);
    chk("rst dealer_sum", dealer_sum, 0);
    chk("rst phase", phase, 0);
    chk("rst done", done, 0);
    chk("rst verdict", {win, lose, draw, blackjack}, 0);
    reset = 0;

    foreach (vecs[i]) begin
      for (int j = 0; j < 24; j++)
        cards[j] = (j < 8 && vecs[i].c[j] != 0) ? int'(vecs[i].c[j]) : $urandom_range(1, 13);
      run_round($sformatf("vec%0d", i), cards, vecs[i].thr, vecs[i].ps, vecs[i].ds,
                vecs[i].w, vecs[i].l, vecs[i].dr, vecs[i].bj);
    end

    for (int i = 0; i < 40; i++) begin
      int thr;
      for (int j = 0; j < 24; j++) cards[j] = $urandom_range(1, 13);
      thr = $urandom_range(12, 21);
      model_round(cards, thr, mps, mds, mw, ml, mdr, mbj, ncards, nhits, dest);
      run_round($sformatf("rand%0d", i), cards, thr, mps, mds, mw, ml, mdr, mbj);
    end

    // Blackjack: no further requests while the verdict is held.
    for (int j = 0; j < 24; j++)
      cards[j] = (j < 8 && vecs[1].c[j] != 0) ? int'(vecs[1].c[j]) : $urandom_range(1, 13);
    run_round("bj_hold", cards, 12, 21, 16, 1, 0, 0, 1);
    any_req = 0;
    for (int j = 0; j < 10; j++) begin
      @(negedge clk);
      any_req |= card_req;
    end
    chk("bj_hold no_req", any_req, 0);
    chk("bj_hold done", done, 1);

    // hit and stand together: stand wins, no P_DRAW.
    do_reset();
    start = 1;
    @(negedge clk);
    start = 0;
    give_card("hs", 10); give_card("hs", 10); give_card("hs", 6); give_card("hs", 5);
    chk("hs phase_player", phase, 5);
    hit = 1; stand = 1;
    @(negedge clk);
    hit = 0; stand = 0;
    chk("hs phase_dealer", phase, 7);
    chk("hs done_low", done, 0);
    give_card("hs", 3);
    n = 0;
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("hs done", done, 1);
    chk("hs player_sum", player_sum, 16);
    chk("hs dealer_sum", dealer_sum, 18);
    chk("hs lose", lose, 1);

    // Invalid ranks are never accepted.
    do_reset();
    start = 1;
    @(negedge clk);
    start = 0;
    n = 0;
    while (!card_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    card_valid = 1; card_value = 5'd0;
    @(negedge clk);
    chk("inv0 card_req", card_req, 1);
    chk("inv0 player_sum", player_sum, 0);
    chk("inv0 phase", phase, 1);
    card_value = 5'd14;
    @(negedge clk);
    chk("inv14 card_req", card_req, 1);
    chk("inv14 player_sum", player_sum, 0);
    chk("inv14 dealer_sum", dealer_sum, 0);
    card_value = 5'd3;
    @(negedge clk);
    card_valid = 0;
    chk("inv3 player_sum", player_sum, 3);
    chk("inv3 card_req", card_req, 0);
    chk("inv3 phase", phase, 2);

    // Reset during P_DRAW with a card on offer.
    do_reset();
    start = 1;
    @(negedge clk);
    start = 0;
    give_card("rd", 10); give_card("rd", 10); give_card("rd", 6); give_card("rd", 5);
    hit = 1;
    @(negedge clk);
    hit = 0;
    chk("rd phase_pdraw", phase, 6);
    n = 0;
    while (!card_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("rd card_req", card_req, 1);
    reset = 1; card_valid = 1; card_value = 5'd9;
    @(negedge clk);
    reset = 0; card_valid = 0;
    chk("rd phase", phase, 0);
    chk("rd card_req0", card_req, 0);
    chk("rd card_dest", card_dest, 0);
    chk("rd player_sum", player_sum, 0);
    chk("rd dealer_sum", dealer_sum, 0);
    chk("rd flags", {done, win, lose, draw, blackjack}, 0);
    for (int j = 0; j < 24; j++)
      cards[j] = (j < 8 && vecs[0].c[j] != 0) ? int'(vecs[0].c[j]) : $urandom_range(1, 13);
    run_round("rd fresh", cards, 12, 15, 18, 0, 1, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
